// File: rtl/vio_responder.sv
// rtl/vio_responder.sv - vio channel far end: burst parser, write FIFO, status/summary registers
// Frames of header + N words become addressed writes drained through a FWFT FIFO to cfg_*.
module vio_responder #(
   parameter int FIFO_DEPTH = 16,
   parameter int LEVEL_W    = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vio_en,
   input  logic        vio_strobe,
   input  logic [15:0] vio_din,
   output logic [15:0] vio_dout,
   output logic [15:0] vio_cfg,
   output logic        cfg_wr,
   output logic [7:0]  cfg_addr,
   output logic [15:0] cfg_data,
   input  logic        cfg_ready
);

   localparam int PTR_W = LEVEL_W - 1;

   typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

   state_t             state_q, state_d;
   logic               en_q;
   logic [7:0]         addr_q, addr_d;
   logic [7:0]         remain_q, remain_d;
   logic [7:0]         frames_q, frames_d;
   logic               ovf_q, ovf_d;
   logic               short_q, short_d;
   logic               extra_q, extra_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [15:0]        dout_q, dout_d;
   logic [15:0]        cfg_q, cfg_d;
   logic [23:0]        mem_q [FIFO_DEPTH];
   logic               push_req, push, pop, full;

   assign cfg_wr   = (level_q != '0);
   assign pop      = cfg_wr & cfg_ready;
   assign full     = (level_q == LEVEL_W'(FIFO_DEPTH));
   assign cfg_addr = cfg_wr ? mem_q[rd_ptr_q][23:16] : 8'h00;
   assign cfg_data = cfg_wr ? mem_q[rd_ptr_q][15:0] : 16'h0000;
   assign vio_dout = dout_q;
   assign vio_cfg  = cfg_q;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      frames_d = frames_q;
      ovf_d    = ovf_q;
      short_d  = short_q;
      extra_d  = extra_q;
      push_req = 1'b0;

      case (state_q)
         IDLE: begin
            if (vio_en && !en_q) begin
               state_d = HDR;
               ovf_d   = 1'b0;
               short_d = 1'b0;
               extra_d = 1'b0;
            end
         end
         HDR: begin
            if (vio_strobe) begin
               addr_d   = vio_din[7:0];
               remain_d = vio_din[15:8];
               state_d  = (vio_din[15:8] == 8'd0) ? DONE : DATA;
            end
         end
         DATA: begin
            if (vio_strobe) begin
               push_req = 1'b1;
               addr_d   = addr_q + 8'd1;
               remain_d = remain_q - 8'd1;
               if (remain_q == 8'd1) state_d = DONE;
            end
         end
         DONE: begin
            if (vio_strobe) extra_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // A word arriving with the falling enable is consumed before the frame closes.
      if (state_q != IDLE && !vio_en) begin
         if (state_d == DATA && remain_d != 8'd0) short_d = 1'b1;
         state_d  = IDLE;
         frames_d = frames_q + 8'd1;
      end

      push = push_req & (!full | pop);
      if (push_req && full && !pop) ovf_d = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      level_d  = level_q + LEVEL_W'(push) - LEVEL_W'(pop);

      dout_d = {(state_d != IDLE) || (level_d != '0), ovf_d, short_d, extra_d,
                {(12 - LEVEL_W){1'b0}}, level_d};
      cfg_d  = {(state_d != IDLE), ovf_d | short_d | extra_d, 6'b0, frames_d};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         en_q     <= 1'b0;
         addr_q   <= '0;
         remain_q <= '0;
         frames_q <= '0;
         ovf_q    <= 1'b0;
         short_q  <= 1'b0;
         extra_q  <= 1'b0;
         level_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dout_q   <= '0;
         cfg_q    <= '0;
      end else begin
         state_q  <= state_d;
         en_q     <= vio_en;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         frames_q <= frames_d;
         ovf_q    <= ovf_d;
         short_q  <= short_d;
         extra_q  <= extra_d;
         level_q  <= level_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         dout_q   <= dout_d;
         cfg_q    <= cfg_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {addr_q, vio_din};
   end

endmodule

// File: tb/tb_vio_responder.sv
// tb/tb_vio_responder.sv - scoreboard bench for vio_responder
module tb_vio_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        vio_en;
   logic        vio_strobe;
   logic [15:0] vio_din;
   logic [15:0] vio_dout;
   logic [15:0] vio_cfg;
   logic        cfg_wr;
   logic [7:0]  cfg_addr;
   logic [15:0] cfg_data;
   logic        cfg_ready;

   int errors = 0;
   int checks = 0;
   logic [23:0] exp_q [$];

   vio_responder #(.FIFO_DEPTH(16), .LEVEL_W(5)) dut (
      .clk(clk), .reset(reset), .vio_en(vio_en), .vio_strobe(vio_strobe),
      .vio_din(vio_din), .vio_dout(vio_dout), .vio_cfg(vio_cfg),
      .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe_word(input logic [15:0] w);
      vio_din    = w;
      vio_strobe = 1'b1;
      tick();
      vio_strobe = 1'b0;
      tick();
   endtask

   task automatic data_word(input logic [7:0] a, input logic [15:0] w, input bit expect_write);
      if (expect_write) exp_q.push_back({a, w});
      strobe_word(w);
   endtask

   task automatic frame_start();
      vio_en = 1'b1;
      tick();
      tick();
   endtask

   task automatic frame_end();
      vio_en = 1'b0;
      tick();
      tick();
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      tick();
      check(tag, exp_q.size(), 0);
   endtask

   // Pops are compared on the falling edge, away from the edge that performs them.
   always @(negedge clk) begin
      if (!reset && cfg_wr && cfg_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {8'h0, cfg_addr, cfg_data}, 32'hFFFF_FFFF);
         end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            check("wr_addr", cfg_addr, e[23:16]);
            check("wr_data", cfg_data, e[15:0]);
         end
      end
   end

   initial begin
      reset      = 1'b1;
      vio_en     = 1'b0;
      vio_strobe = 1'b0;
      vio_din    = '0;
      cfg_ready  = 1'b0;
      tick();
      tick();
      check("rst_dout", vio_dout, 16'h0000);
      check("rst_cfg", vio_cfg, 16'h0000);
      check("rst_wr", cfg_wr, 1'b0);
      reset = 1'b0;
      tick();

      // 1: basic three-word burst, first-word fall-through latency
      cfg_ready = 1'b1;
      frame_start();
      strobe_word(16'h0310);
      exp_q.push_back({8'h10, 16'hAAAA});
      vio_din    = 16'hAAAA;
      vio_strobe = 1'b1;
      tick();
      vio_strobe = 1'b0;
      check("fwft_wr", cfg_wr, 1'b1);
      tick();
      data_word(8'h11, 16'hBBBB, 1);
      data_word(8'h12, 16'hCCCC, 1);
      frame_end();
      wait_drain("t1_drain");
      check("t1_cfg", vio_cfg, 16'h0001);
      check("t1_dout", vio_dout, 16'h0000);

      // 2: address wraps 0xFF -> 0x00
      frame_start();
      strobe_word(16'h02FF);
      data_word(8'hFF, 16'h0001, 1);
      data_word(8'h00, 16'h0002, 1);
      frame_end();
      wait_drain("t2_drain");
      check("t2_cfg", vio_cfg, 16'h0002);

      // 3: overflow with downstream stalled; only the first 16 survive
      cfg_ready = 1'b0;
      frame_start();
      strobe_word(16'h1400);
      for (int i = 0; i < 20; i++) data_word(8'(i), 16'h3000 + 16'(i), i < 16);
      frame_end();
      check("t3_dout", vio_dout, 16'hC010);
      check("t3_cfg", vio_cfg, 16'h4003);
      check("t3_hold_addr", cfg_addr, 8'h00);
      check("t3_hold_data", cfg_data, 16'h3000);
      cfg_ready = 1'b1;
      wait_drain("t3_drain");
      check("t3_dout_drained", vio_dout, 16'h4000);

      // 4: short frame, cleared by the next enable rise
      frame_start();
      check("t4_rise_clear", vio_dout, 16'h8000);
      strobe_word(16'h0420);
      data_word(8'h20, 16'h4444, 1);
      data_word(8'h21, 16'h5555, 1);
      frame_end();
      wait_drain("t4_drain");
      check("t4_short", vio_dout, 16'h2000);
      check("t4_cfg", vio_cfg, 16'h4004);

      // 5a: zero-length header followed by an extra word
      frame_start();
      check("t5_short_clear", vio_dout, 16'h8000);
      strobe_word(16'h0000);
      data_word(8'h00, 16'h1234, 0);
      frame_end();
      tick();
      check("t5_extra", vio_dout, 16'h1000);
      check("t5_cfg", vio_cfg, 16'h4005);

      // 5b: last word strobed in the same cycle the enable falls
      frame_start();
      strobe_word(16'h0150);
      exp_q.push_back({8'h50, 16'h5555});
      vio_din    = 16'h5555;
      vio_strobe = 1'b1;
      vio_en     = 1'b0;
      tick();
      vio_strobe = 1'b0;
      tick();
      wait_drain("t5b_drain");
      check("t5b_dout", vio_dout, 16'h0000);
      check("t5b_cfg", vio_cfg, 16'h0006);

      // 6: reset with queued entries discards them
      cfg_ready = 1'b0;
      frame_start();
      strobe_word(16'h0560);
      for (int i = 0; i < 5; i++) data_word(8'h60 + 8'(i), 16'h6000 + 16'(i), 0);
      frame_end();
      check("t6_level", vio_dout, 16'h8005);
      reset = 1'b1;
      #2;
      check("t6_rst_wr", cfg_wr, 1'b0);
      check("t6_rst_dout", vio_dout, 16'h0000);
      check("t6_rst_cfg", vio_cfg, 16'h0000);
      cfg_ready = 1'b1;
      tick();
      tick();
      check("t6_rst_wr_hold", cfg_wr, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("t6_post_wr", cfg_wr, 1'b0);
      check("t6_post_cfg", vio_cfg, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
